piso_tx: RTL and testbench

//  Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a load strobe
//  and shifts it out one bit per clock, with a per-bit strobe and an end-of-word pulse.
//  It is the sending end of the serial link whose receiver is a WIDTH-bit SIPO shift

---
 rtl/piso_tx_pkg.sv | 5 +
 rtl/piso_tx_bit_counter.sv | 19 +
 rtl/piso_tx.sv | 71 +++++++
 tb/tb_piso_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: state encoding and default word width shared by the transmitter and its benches
package piso_tx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
    localparam int DEFAULT_WIDTH = 6;
endpackage

// File: rtl/piso_tx_bit_counter.sv
// piso_tx_bit_counter: bit index counter that saturates at WIDTH-1 and flags terminal count
module piso_tx_bit_counter import piso_tx_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc_o
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tc_o = cnt_q == CW'(WIDTH - 1);
    always_comb cnt_d = clr ? '0 : (en && !tc_o) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with per-bit valid strobe and end-of-word pulse
module piso_tx import piso_tx_pkg::*; #(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    state_e state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic dout_d, valid_d, busy_d, done_d, accept, tc;
    // a word may be accepted in DONE as well as IDLE, giving back-to-back words
    assign accept = load && !busy && state_q != SHIFT;
    piso_tx_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_q == SHIFT),
        .clr (accept),
        .tc_o(tc)
    );
    always_comb begin
        state_d = IDLE;
        sr_d    = sr_q;
        dout_d  = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_q == SHIFT) begin
            if (tc) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = SHIFT;
                sr_d    = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
                dout_d  = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
        end else if (accept) begin
            state_d = SHIFT;
            sr_d    = din;
            dout_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized scoreboard bench for piso_tx, MSB-first and LSB-first instances side by side
module tb_piso_tx;
    localparam int W = 6;
    logic clk = 1'b0;
    logic rst, load;
    logic [W-1:0] din;
    logic dout_m, valid_m, busy_m, done_m;
    logic dout_l, valid_l, busy_l, done_l;
    int checks = 0;
    int errors = 0;
    int t = 0;
    bit run = 1'b0;
    logic bq_m[$], bq_l[$];
    logic [W-1:0] wq_m[$], wq_l[$];
    logic [W-1:0] sipo_m = '0, sipo_l = '0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .dout(dout_m), .dout_valid(valid_m), .busy(busy_m), .done(done_m)
    );
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .dout(dout_l), .dout_valid(valid_l), .busy(busy_l), .done(done_l)
    );

    // reference: t counts cycles left in a word's life; W bits, then one done cycle
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            bq_m.delete();
            bq_l.delete();
            wq_m.delete();
            wq_l.delete();
        end else if (load && t <= 1) begin
            logic [W-1:0] rev;
            t = W + 1;
            for (int i = 0; i < W; i++) begin
                bq_m.push_back(din[W-1-i]);
                bq_l.push_back(din[i]);
                rev[W-1-i] = din[i];
            end
            wq_m.push_back(din);
            wq_l.push_back(rev);
        end else if (t > 0) begin
            t--;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input bit msb, input logic d, input logic v, input logic b, input logic dn);
        string n = msb ? "msb" : "lsb";
        logic e;
        chk({n, "_busy"}, W'(b), W'(t >= 2));
        chk({n, "_valid"}, W'(v), W'(t >= 2));
        chk({n, "_done"}, W'(dn), W'(t == 1));
        if (v) begin
            if ((msb ? bq_m.size() : bq_l.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_bit: got %b expected no bit at %0t", n, d, $time);
            end else begin
                e = msb ? bq_m.pop_front() : bq_l.pop_front();
                chk({n, "_bit"}, W'(d), W'(e));
            end
            if (msb) sipo_m = {sipo_m[W-2:0], d};
            else     sipo_l = {sipo_l[W-2:0], d};
        end else begin
            chk({n, "_idle"}, W'(d), '0);
        end
        if (dn) begin
            if ((msb ? wq_m.size() : wq_l.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_word: got done expected no done at %0t", n, $time);
            end else begin
                chk({n, "_sipo"}, msb ? sipo_m : sipo_l, msb ? wq_m.pop_front() : wq_l.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            mon(1'b1, dout_m, valid_m, busy_m, done_m);
            mon(1'b0, dout_l, valid_l, busy_l, done_l);
        end
    end

    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        rst = r;
        load = l;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        din = '0;
        @(posedge clk);
        #1;
        run = 1'b1;
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 6'b101101);
        idle(W + 3);
        step(1'b0, 1'b1, 6'b110010);
        idle(W);
        step(1'b0, 1'b1, 6'b001111);
        idle(W + 3);
        step(1'b0, 1'b1, 6'b000001);
        repeat (3) step(1'b0, 1'b1, 6'b111111);
        idle(W + 2);
        step(1'b0, 1'b1, 6'b100110);
        idle(2);
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b1, 6'b000011);
        idle(W + 3);
        step(1'b1, 1'b1, 6'b111000);
        idle(2);
        repeat (3 * (W + 1) + 2) step(1'b0, 1'b1, W'($urandom));
        idle(W + 3);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, W'($urandom));
        idle(W + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
